// File: rtl/tdm_pkg.sv
// Shared types and constants for the two-channel TDM demultiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Optional feature macro: TDM_DEMUX2_PARITY_EN adds the SLOT_P state.
package tdm_pkg;

  // Widest time slot the demux is intended to carry.
  localparam int TDM_MAX_W = 32;

  // Frame-alignment states. Encodings are fixed so state dumps stay
  // comparable between the 2-slot and 3-slot builds.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SLOT1  = 2'd1
`ifdef TDM_DEMUX2_PARITY_EN
    ,
    ST_SLOT_P = 2'd2
`endif
  } tdm_state_e;

endpackage

// File: rtl/tdm_parity_chk.sv
// Even-parity check of a staged frame against the trailing parity bit.
// Latency: combinational, zero cycles.
// Backpressure: none; evaluates whatever is presented.
//
// Ports: stage0/stage1 - staged channel values; par_bit - received parity
//        bit; par_ok - high when XOR of all staged bits equals par_bit.
module tdm_parity_chk #(
  parameter int W = 1
) (
  input  logic [W-1:0] stage0,
  input  logic [W-1:0] stage1,
  input  logic         par_bit,
  output logic         par_ok
);

  assign par_ok = ((^stage0) ^ (^stage1)) == par_bit;

endmodule

// File: rtl/tdm_demux2.sv
// Splits a TDM stream of 2-slot frames (3 with parity) into two registered channels.
// Latency: channels and out_valid update one cycle after the final slot is sampled.
// Backpressure: none; din_valid=0 simply pauses the frame, with no timeout.
//
// Ports: clk, rst (async, active-high); din/din_valid/sync - input stream,
//        sync tags slot 0; ch0/ch1 - last committed frame; out_valid - commit
//        pulse; frame_err - sync seen mid-frame; parity_err - bad parity slot.
// Macro: TDM_DEMUX2_PARITY_EN - adds a third even-parity slot and parity_err.
// W legal range is 1..tdm_pkg::TDM_MAX_W.
module tdm_demux2
  import tdm_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         sync,
  output logic [W-1:0] ch0,
  output logic [W-1:0] ch1,
  output logic         out_valid,
  output logic         frame_err
`ifdef TDM_DEMUX2_PARITY_EN
  ,
  output logic         parity_err
`endif
);

  tdm_state_e   state_q, state_d;
  logic [W-1:0] stage0_q, stage0_d;
  logic [W-1:0] stage1_q, stage1_d;
  logic         commit;
  logic [W-1:0] commit_ch1;
  logic         ferr_d;
  logic         perr_d;
  logic         par_ok;

`ifdef TDM_DEMUX2_PARITY_EN
  tdm_parity_chk #(.W(W)) u_parity_chk (
    .stage0  (stage0_q),
    .stage1  (stage1_q),
    .par_bit (din[0]),
    .par_ok  (par_ok)
  );
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    stage0_d   = stage0_q;
    stage1_d   = stage1_q;
    commit     = 1'b0;
    commit_ch1 = stage1_q;
    ferr_d     = 1'b0;
    perr_d     = 1'b0;
    if (din_valid) begin
      if (sync) begin
        // A sync always restarts framing; only mid-frame is it an error.
        ferr_d   = (state_q != ST_IDLE);
        stage0_d = din;
        state_d  = ST_SLOT1;
      end else begin
        case (state_q)
          ST_SLOT1: begin
            stage1_d = din;
`ifdef TDM_DEMUX2_PARITY_EN
            state_d  = ST_SLOT_P;
`else
            // Final slot: commit straight from din, staging is written
            // in the same edge.
            commit     = 1'b1;
            commit_ch1 = din;
            state_d    = ST_IDLE;
`endif
          end
`ifdef TDM_DEMUX2_PARITY_EN
          ST_SLOT_P: begin
            state_d = ST_IDLE;
            if (par_ok) commit = 1'b1;
            else        perr_d = 1'b1;
          end
`endif
          default: begin
            // Unsynchronised sample while idle: drop silently.
            state_d = ST_IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      stage0_q  <= '0;
      stage1_q  <= '0;
      ch0       <= '0;
      ch1       <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      stage0_q  <= stage0_d;
      stage1_q  <= stage1_d;
      out_valid <= commit;
      frame_err <= ferr_d;
      if (commit) begin
        ch0 <= stage0_q;
        ch1 <= commit_ch1;
      end
    end
  end

`ifdef TDM_DEMUX2_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= perr_d;
  end
`else
  // perr_d and par_ok only matter in the parity build.
  logic unused_par;
  assign unused_par = perr_d & par_ok;
`endif

endmodule

// File: doc/tdm_demux2.md
TDM_DEMUX2 -- requirements
Module: tdm_demux2

Interface
REQ-001 Parameter W, default 1, data width of each time slot; legal range 1..32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 din  input  W  time-division-multiplexed sample.
REQ-005 din_valid  input  1  din carries a valid slot this cycle.
REQ-006 sync  input  1  marks the current valid sample as slot 0 of a frame; ignored when din_valid=0.
REQ-007 ch0  output  W  registered channel-0 value of the last committed frame.
REQ-008 ch1  output  W  registered channel-1 value of the last committed frame.
REQ-009 out_valid  output  1  one-cycle pulse, high in the cycle after a frame commits.
REQ-010 frame_err  output  1  one-cycle pulse on sync arriving mid-frame.
REQ-011 parity_err  output  1  one-cycle pulse on parity mismatch; present only when TDM_DEMUX2_PARITY_EN is defined.

Function
REQ-012 The FSM SHALL have states IDLE, SLOT1 and SLOT_P; SLOT_P exists only with TDM_DEMUX2_PARITY_EN.
REQ-013 IDLE, din_valid=1 and sync=1: din -> stage0; next state SLOT1.
REQ-014 IDLE, din_valid=1 and sync=0: sample discarded, no error, stay IDLE.
REQ-015 SLOT1, din_valid=1 and sync=0: din -> stage1; next state IDLE (commit) without the macro, or SLOT_P with it.
REQ-016 Any non-IDLE state, din_valid=1 and sync=1: frame_err pulses next cycle; partial frame dropped; din -> stage0; next state SLOT1.
REQ-017 din_valid=0 in any state: state and staging hold; no stall timeout.
REQ-018 Commit: ch0<=stage0, ch1<=stage1, out_valid=1 for exactly one cycle, visible the cycle after the final slot is sampled.
REQ-019 ch0/ch1 SHALL hold their value between commits; a dropped frame never alters them.
REQ-020 Back-to-back frames with no idle cycles SHALL be accepted; the first slot of the next frame may be sampled in the cycle out_valid is high.
REQ-021 frame_err and out_valid SHALL never pulse in the same cycle.

Reset
REQ-022 rst=1 SHALL force state IDLE, stage0/stage1/ch0/ch1 to 0, and out_valid/frame_err/parity_err to 0, independent of clk.
REQ-023 Reset asserted mid-frame discards the partial frame; the first frame after release starts only on a sync-qualified sample.

Configuration
REQ-024 Macro TDM_DEMUX2_PARITY_EN: when defined, frames are 3 slots; the third slot's din[0] SHALL equal the XOR of all bits of stage0 and stage1 (even parity), and din[W-1:1] is ignored.
REQ-025 With the macro, SLOT_P with din_valid=1 and sync=0: a match commits per REQ-018; a mismatch pulses parity_err for one cycle, does not commit, and returns to IDLE.
REQ-026 With the macro, sync in SLOT_P follows REQ-016.
REQ-027 Without the macro, frames are 2 slots, parity_err and SLOT_P do not exist, and the port list omits parity_err.

Structure
REQ-028 Package tdm_pkg SHALL hold the state enum type and the maximum-width constant (32).
REQ-029 One sub-module, tdm_parity_chk (combinational parity reduce of stage0/stage1 against din[0]), SHALL be instantiated only under TDM_DEMUX2_PARITY_EN.

Verification
REQ-030 W=4, no macro: (din=4'hA, sync=1), (din=4'h5, sync=0) on consecutive valid cycles -> next cycle ch0=A, ch1=5, out_valid=1 for one cycle.
REQ-031 W=4, no macro: (A, sync=1), then (3, sync=1) -> frame_err=1 for one cycle; then (7, sync=0) -> ch0=3, ch1=7, out_valid=1; old ch0/ch1 unchanged until then.
REQ-032 W=1: valid samples with sync=0 while IDLE (1, 0, 1) -> no out_valid, no frame_err, ch0=ch1=0.
REQ-033 W=4, no macro: frame slot 0 sampled, rst pulsed for 3 ns, then slot 1 (sync=0) -> ignored; outputs stay 0.
REQ-034 W=1, macro defined: slots 1, 0, parity 1 -> commit ch0=1, ch1=0; slots 1, 1, parity 1 -> parity_err=1, no out_valid, ch0/ch1 unchanged.
REQ-035 W=4, no macro: 3 frames back-to-back with din_valid held high -> 3 out_valid pulses, every other cycle, with correct channel values.
